// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, ALU
// control fields, FSM states and the latched opcode class.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    localparam logic [1:0] ALUOP_ITYPE = 2'b00;
    localparam logic [1:0] ALUOP_ADD   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] ALUSRCB_RS2  = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM  = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CLS_LOAD  = 2'd0,
        CLS_STORE = 2'd1,
        CLS_RTYPE = 2'd2,
        CLS_ITYPE = 2'd3
    } op_class_t;

endpackage

// File: rtl/multicycle_controller_opcode_class_decode.sv
// Combinational opcode classifier; exactly one output is high for any opcode.
module opcode_class_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic       load_o,
    output logic       store_o,
    output logic       rtype_o,
    output logic       itype_o,
    output logic       illegal_o
);

    // One-hot class flags from the raw opcode
    always_comb begin
        load_o    = 1'b0;
        store_o   = 1'b0;
        rtype_o   = 1'b0;
        itype_o   = 1'b0;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_LOAD:  load_o    = 1'b1;
            OP_STORE: store_o   = 1'b1;
            OP_RTYPE: rtype_o   = 1'b1;
            OP_ITYPE: itype_o   = 1'b1;
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with a shared
// request/ready memory port, retire counter and sticky illegal-opcode trap.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             IorD,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             illegal_instr
);

    state_t           state_q, state_d;
    op_class_t        cls_q, cls_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;

    logic       pc_write_s, ir_write_s, iord_s, alu_src_a_s;
    logic [1:0] alu_src_b_s, alu_op_s;
    logic       mem_read_s, mem_write_s, mem_to_reg_s, reg_write_s, instr_done_s;
    logic       dec_load_s, dec_store_s, dec_rtype_s, dec_itype_s, dec_illegal_s;

    opcode_class_decode u_opcode_class_decode (
        .opcode_i  (Opcode),
        .load_o    (dec_load_s),
        .store_o   (dec_store_s),
        .rtype_o   (dec_rtype_s),
        .itype_o   (dec_itype_s),
        .illegal_o (dec_illegal_s)
    );

    // Next-state, datapath strobes and counter update
    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        illegal_d    = illegal_q;
        retired_d    = retired_q;
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        iord_s       = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = ALUSRCB_RS2;
        alu_op_s     = ALUOP_ITYPE;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        instr_done_s = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = ALUSRCB_FOUR;
                alu_op_s    = ALUOP_ADD;
                if (mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_d    = S_DECODE;
                end else begin
                    state_d    = S_FETCH;
                end
            end
            S_DECODE: begin
                // A decoder disagreeing with itself is treated like a bad opcode
                if (dec_illegal_s || !(dec_load_s | dec_store_s | dec_rtype_s | dec_itype_s)) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                    cls_d   = op_class_t'({dec_rtype_s | dec_itype_s, dec_store_s | dec_itype_s});
                end
            end
            S_EXEC: begin
                alu_src_a_s = 1'b1;
                case (cls_q)
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_b_s = ALUSRCB_IMM;
                        alu_op_s    = ALUOP_ADD;
                        state_d     = S_MEM;
                    end
                    CLS_RTYPE: begin
                        alu_src_b_s = ALUSRCB_RS2;
                        alu_op_s    = ALUOP_RTYPE;
                        state_d     = S_WB;
                    end
                    default: begin
                        alu_src_b_s = ALUSRCB_IMM;
                        alu_op_s    = ALUOP_ITYPE;
                        state_d     = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                iord_s = 1'b1;
                if (cls_q == CLS_STORE) begin
                    mem_write_s = 1'b1;
                end else begin
                    mem_read_s  = 1'b1;
                end
                if (mem_ready) begin
                    if (cls_q == CLS_STORE) begin
                        instr_done_s = 1'b1;
                        state_d      = S_FETCH;
                    end else begin
                        state_d      = S_WB;
                    end
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = (cls_q == CLS_LOAD);
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d   = S_TRAP;
                illegal_d = 1'b1;
            end
        endcase

        if (instr_done_s) begin
            retired_d = retired_q + CNT_W'(1);
        end else begin
            retired_d = retired_q;
        end
    end

    // State, class, counter and trap registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cls_q     <= CLS_LOAD;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    // Reset forces every output low combinationally, including live memory requests
    always_comb begin
        if (reset) begin
            PCWrite       = 1'b0;
            IRWrite       = 1'b0;
            IorD          = 1'b0;
            ALUSrcA       = 1'b0;
            ALUSrcB       = 2'b00;
            ALUOp         = 2'b00;
            MemRead       = 1'b0;
            MemWrite      = 1'b0;
            MemtoReg      = 1'b0;
            RegWrite      = 1'b0;
            instr_done    = 1'b0;
            retired       = '0;
            illegal_instr = 1'b0;
        end else begin
            PCWrite       = pc_write_s;
            IRWrite       = ir_write_s;
            IorD          = iord_s;
            ALUSrcA       = alu_src_a_s;
            ALUSrcB       = alu_src_b_s;
            ALUOp         = alu_op_s;
            MemRead       = mem_read_s;
            MemWrite      = mem_write_s;
            MemtoReg      = mem_to_reg_s;
            RegWrite      = reg_write_s;
            instr_done    = instr_done_s;
            retired       = retired_q;
            illegal_instr = illegal_q;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scenario bench for multicycle_controller: per-cycle expected strobe vectors
// go through a scoreboard queue; a CNT_W=4 instance checks counter wrap.
module tb_multicycle_controller;

    // {PCWrite, IRWrite, IorD, ALUSrcA, ALUSrcB, ALUOp, MemRead, MemWrite, MemtoReg, RegWrite, instr_done, illegal_instr}
    localparam logic [13:0] V_ZERO   = 14'd0;
    localparam logic [13:0] V_FW     = {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [13:0] V_FR     = {1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [13:0] V_EX_LS  = {1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [13:0] V_EX_R   = {1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [13:0] V_EX_I   = {1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [13:0] V_MEM_LD = {1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [13:0] V_MEM_SW = {1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [13:0] V_MEM_SD = {1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [13:0] V_WB_LD  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic [13:0] V_WB_ALU = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [13:0] V_TRAP   = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    localparam logic [6:0] J   = 7'b1111111;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;

    typedef struct packed {
        logic        rst;
        logic        mr;
        logic [6:0]  op;
        logic [13:0] exp;
    } stim_t;

    logic        clk = 1'b0;
    logic        reset, mem_ready;
    logic [6:0]  Opcode;
    logic        pcw, irw, iord, srca, memr, memw, m2r, regw, done, ill;
    logic [1:0]  srcb, aluop;
    logic [31:0] retired;
    logic        pcw4, irw4, iord4, srca4, memr4, memw4, m2r4, regw4, done4, ill4;
    logic [1:0]  srcb4, aluop4;
    logic [3:0]  retired4;
    logic [13:0] out_v, out4_v;

    stim_t       stim_q[$];
    logic [13:0] sb_q[$];
    logic [31:0] r_exp;
    int          n_chk, n_pass;
    string       tname;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
        .PCWrite(pcw), .IRWrite(irw), .IorD(iord), .ALUSrcA(srca), .ALUSrcB(srcb),
        .ALUOp(aluop), .MemRead(memr), .MemWrite(memw), .MemtoReg(m2r), .RegWrite(regw),
        .instr_done(done), .retired(retired), .illegal_instr(ill)
    );

    multicycle_controller #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
        .PCWrite(pcw4), .IRWrite(irw4), .IorD(iord4), .ALUSrcA(srca4), .ALUSrcB(srcb4),
        .ALUOp(aluop4), .MemRead(memr4), .MemWrite(memw4), .MemtoReg(m2r4), .RegWrite(regw4),
        .instr_done(done4), .retired(retired4), .illegal_instr(ill4)
    );

    assign out_v  = {pcw, irw, iord, srca, srcb, aluop, memr, memw, m2r, regw, done, ill};
    assign out4_v = {pcw4, irw4, iord4, srca4, srcb4, aluop4, memr4, memw4, m2r4, regw4, done4, ill4};

    task automatic push(input logic r, input logic m, input logic [6:0] o, input logic [13:0] e);
        stim_t s;
        s = '{rst: r, mr: m, op: o, exp: e};
        stim_q.push_back(s);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic test_reset();
        stim_t s; logic [13:0] e; logic [31:0] r_now; int cyc = 0;
        tname = "reset";
        push(1'b1, 1'b1, J, V_ZERO);
        push(1'b1, 1'b0, J, V_ZERO);
        push(1'b0, 1'b0, J, V_FW);
        push(1'b0, 1'b0, J, V_FW);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(posedge clk); #1;
            reset = s.rst; mem_ready = s.mr; Opcode = s.op; sb_q.push_back(s.exp);
            @(negedge clk);
            e = sb_q.pop_front();
            r_now = s.rst ? 32'd0 : r_exp;
            n_chk++;
            if ({out_v, out4_v} !== {e, e}) $display("FAIL %s outputs cyc%0d got=%b/%b exp=%b", tname, cyc, out_v, out4_v, e);
            else n_pass++;
            n_chk++;
            if ({retired, retired4} !== {r_now, r_now[3:0]}) $display("FAIL %s retired cyc%0d got=%0d/%0d exp=%0d", tname, cyc, retired, retired4, r_now);
            else n_pass++;
            if (s.rst) r_exp = 32'd0; else if (e[1]) r_exp = r_exp + 32'd1;
            cyc++;
        end
    endtask

    task automatic test_rtype();
        stim_t s; logic [13:0] e; logic [31:0] r_now; int cyc = 0;
        tname = "rtype";
        push(1'b1, 1'b0, J, V_ZERO);
        push(1'b0, 1'b1, J, V_FR);
        push(1'b0, 1'b1, RT, V_ZERO);
        push(1'b0, 1'b1, J, V_EX_R);
        push(1'b0, 1'b1, J, V_WB_ALU);
        push(1'b0, 1'b0, J, V_FW);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(posedge clk); #1;
            reset = s.rst; mem_ready = s.mr; Opcode = s.op; sb_q.push_back(s.exp);
            @(negedge clk);
            e = sb_q.pop_front();
            r_now = s.rst ? 32'd0 : r_exp;
            n_chk++;
            if ({out_v, out4_v} !== {e, e}) $display("FAIL %s outputs cyc%0d got=%b/%b exp=%b", tname, cyc, out_v, out4_v, e);
            else n_pass++;
            n_chk++;
            if ({retired, retired4} !== {r_now, r_now[3:0]}) $display("FAIL %s retired cyc%0d got=%0d/%0d exp=%0d", tname, cyc, retired, retired4, r_now);
            else n_pass++;
            if (s.rst) r_exp = 32'd0; else if (e[1]) r_exp = r_exp + 32'd1;
            cyc++;
        end
    endtask

    task automatic test_load_waits();
        stim_t s; logic [13:0] e; logic [31:0] r_now; int cyc = 0;
        tname = "load_waits";
        push(1'b1, 1'b0, J, V_ZERO);
        push(1'b0, 1'b0, J, V_FW);
        push(1'b0, 1'b0, J, V_FW);
        push(1'b0, 1'b1, J, V_FR);
        push(1'b0, rnd(), LD, V_ZERO);
        push(1'b0, rnd(), J, V_EX_LS);
        push(1'b0, 1'b0, J, V_MEM_LD);
        push(1'b0, 1'b0, J, V_MEM_LD);
        push(1'b0, 1'b1, J, V_MEM_LD);
        push(1'b0, rnd(), J, V_WB_LD);
        push(1'b0, 1'b0, J, V_FW);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(posedge clk); #1;
            reset = s.rst; mem_ready = s.mr; Opcode = s.op; sb_q.push_back(s.exp);
            @(negedge clk);
            e = sb_q.pop_front();
            r_now = s.rst ? 32'd0 : r_exp;
            n_chk++;
            if ({out_v, out4_v} !== {e, e}) $display("FAIL %s outputs cyc%0d got=%b/%b exp=%b", tname, cyc, out_v, out4_v, e);
            else n_pass++;
            n_chk++;
            if ({retired, retired4} !== {r_now, r_now[3:0]}) $display("FAIL %s retired cyc%0d got=%0d/%0d exp=%0d", tname, cyc, retired, retired4, r_now);
            else n_pass++;
            if (s.rst) r_exp = 32'd0; else if (e[1]) r_exp = r_exp + 32'd1;
            cyc++;
        end
    endtask

    task automatic test_store_waits();
        stim_t s; logic [13:0] e; logic [31:0] r_now; int cyc = 0;
        tname = "store_waits";
        push(1'b1, 1'b0, J, V_ZERO);
        push(1'b0, 1'b1, J, V_FR);
        push(1'b0, rnd(), ST, V_ZERO);
        push(1'b0, rnd(), J, V_EX_LS);
        push(1'b0, 1'b0, J, V_MEM_SW);
        push(1'b0, 1'b0, J, V_MEM_SW);
        push(1'b0, 1'b0, J, V_MEM_SW);
        push(1'b0, 1'b1, J, V_MEM_SD);
        push(1'b0, 1'b0, J, V_FW);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(posedge clk); #1;
            reset = s.rst; mem_ready = s.mr; Opcode = s.op; sb_q.push_back(s.exp);
            @(negedge clk);
            e = sb_q.pop_front();
            r_now = s.rst ? 32'd0 : r_exp;
            n_chk++;
            if ({out_v, out4_v} !== {e, e}) $display("FAIL %s outputs cyc%0d got=%b/%b exp=%b", tname, cyc, out_v, out4_v, e);
            else n_pass++;
            n_chk++;
            if ({retired, retired4} !== {r_now, r_now[3:0]}) $display("FAIL %s retired cyc%0d got=%0d/%0d exp=%0d", tname, cyc, retired, retired4, r_now);
            else n_pass++;
            if (s.rst) r_exp = 32'd0; else if (e[1]) r_exp = r_exp + 32'd1;
            cyc++;
        end
    endtask

    task automatic test_trap();
        stim_t s; logic [13:0] e; logic [31:0] r_now; int cyc = 0;
        tname = "trap";
        push(1'b1, 1'b0, J, V_ZERO);
        push(1'b0, 1'b1, J, V_FR);
        push(1'b0, rnd(), 7'b1111111, V_ZERO);
        for (int i = 0; i < 20; i++) push(1'b0, rnd(), 7'($urandom), V_TRAP);
        push(1'b1, 1'b1, J, V_ZERO);
        push(1'b0, 1'b0, J, V_FW);
        push(1'b0, 1'b1, J, V_FR);
        push(1'b0, rnd(), RT, V_ZERO);
        push(1'b0, rnd(), J, V_EX_R);
        push(1'b0, rnd(), J, V_WB_ALU);
        push(1'b0, 1'b0, J, V_FW);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(posedge clk); #1;
            reset = s.rst; mem_ready = s.mr; Opcode = s.op; sb_q.push_back(s.exp);
            @(negedge clk);
            e = sb_q.pop_front();
            r_now = s.rst ? 32'd0 : r_exp;
            n_chk++;
            if ({out_v, out4_v} !== {e, e}) $display("FAIL %s outputs cyc%0d got=%b/%b exp=%b", tname, cyc, out_v, out4_v, e);
            else n_pass++;
            n_chk++;
            if ({retired, retired4} !== {r_now, r_now[3:0]}) $display("FAIL %s retired cyc%0d got=%0d/%0d exp=%0d", tname, cyc, retired, retired4, r_now);
            else n_pass++;
            if (s.rst) r_exp = 32'd0; else if (e[1]) r_exp = r_exp + 32'd1;
            cyc++;
        end
    endtask

    task automatic test_reset_mid_store();
        stim_t s; logic [13:0] e; logic [31:0] r_now; int cyc = 0;
        tname = "reset_mid_store";
        push(1'b1, 1'b0, J, V_ZERO);
        push(1'b0, 1'b1, J, V_FR);
        push(1'b0, rnd(), ST, V_ZERO);
        push(1'b0, rnd(), J, V_EX_LS);
        push(1'b0, 1'b0, J, V_MEM_SW);
        // ready arriving with reset must not retire the store
        push(1'b1, 1'b1, J, V_ZERO);
        push(1'b0, 1'b0, J, V_FW);
        push(1'b0, 1'b0, J, V_FW);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(posedge clk); #1;
            reset = s.rst; mem_ready = s.mr; Opcode = s.op; sb_q.push_back(s.exp);
            @(negedge clk);
            e = sb_q.pop_front();
            r_now = s.rst ? 32'd0 : r_exp;
            n_chk++;
            if ({out_v, out4_v} !== {e, e}) $display("FAIL %s outputs cyc%0d got=%b/%b exp=%b", tname, cyc, out_v, out4_v, e);
            else n_pass++;
            n_chk++;
            if ({retired, retired4} !== {r_now, r_now[3:0]}) $display("FAIL %s retired cyc%0d got=%0d/%0d exp=%0d", tname, cyc, retired, retired4, r_now);
            else n_pass++;
            if (s.rst) r_exp = 32'd0; else if (e[1]) r_exp = r_exp + 32'd1;
            cyc++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s; logic [13:0] e; logic [31:0] r_now; int cyc = 0;
        tname = "back_to_back";
        push(1'b1, 1'b0, J, V_ZERO);
        for (int i = 0; i < 16; i++) begin
            push(1'b0, 1'b1, J, V_FR);
            push(1'b0, rnd(), IT, V_ZERO);
            push(1'b0, rnd(), J, V_EX_I);
            push(1'b0, rnd(), J, V_WB_ALU);
        end
        push(1'b0, 1'b0, J, V_FW);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(posedge clk); #1;
            reset = s.rst; mem_ready = s.mr; Opcode = s.op; sb_q.push_back(s.exp);
            @(negedge clk);
            e = sb_q.pop_front();
            r_now = s.rst ? 32'd0 : r_exp;
            n_chk++;
            if ({out_v, out4_v} !== {e, e}) $display("FAIL %s outputs cyc%0d got=%b/%b exp=%b", tname, cyc, out_v, out4_v, e);
            else n_pass++;
            n_chk++;
            if ({retired, retired4} !== {r_now, r_now[3:0]}) $display("FAIL %s retired cyc%0d got=%0d/%0d exp=%0d", tname, cyc, retired, retired4, r_now);
            else n_pass++;
            if (s.rst) r_exp = 32'd0; else if (e[1]) r_exp = r_exp + 32'd1;
            cyc++;
        end
        n_chk++;
        if (retired4 !== 4'd0 || retired !== 32'd16) $display("FAIL %s wrap got=%0d/%0d exp=0/16", tname, retired4, retired);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b0; Opcode = 7'd0;
        r_exp = 32'd0; n_chk = 0; n_pass = 0;
        test_reset();
        test_rtype();
        test_load_waits();
        test_store_waits();
        test_trap();
        test_reset_mid_store();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
